// File: rtl/phase_search_ctrl.sv
// Automatic sampling-phase search: sweep four phases, measure errors per window,
// lock on the best phase and restart the search when the locked error rate degrades.
module phase_search_ctrl #(
  parameter int unsigned SETTLE_SYMS = 16,
  parameter int unsigned WINDOW_SYMS = 511,
  parameter int unsigned ERR_W       = 10,
  parameter int unsigned RELOCK_THR  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic             i_error,
  output logic [1:0]       o_phase,
  output logic             o_locked,
  output logic             o_busy,
  output logic [ERR_W-1:0] o_best_err,
  output logic             o_relock
);

  localparam int unsigned MaxSyms = (WINDOW_SYMS > SETTLE_SYMS) ? WINDOW_SYMS : SETTLE_SYMS;
  localparam int unsigned CntW    = $clog2(MaxSyms + 1);

  localparam logic [CntW-1:0]  SettleEnd = CntW'(SETTLE_SYMS);
  localparam logic [CntW-1:0]  WindowEnd = CntW'(WINDOW_SYMS);
  localparam logic [ERR_W-1:0] RelockThr = ERR_W'(RELOCK_THR);

  typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StEval, StLock} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       cur_phase_q, cur_phase_d;
  logic [1:0]       best_phase_q, best_phase_d;
  logic [ERR_W-1:0] best_err_q, best_err_d;
  logic [1:0]       phase_q, phase_d;
  logic [ERR_W-1:0] best_err_out_q, best_err_out_d;
  logic             relock_q, relock_d;

  logic [CntW-1:0]  sym_inc;
  logic [ERR_W-1:0] err_next;
  logic [ERR_W-1:0] eval_best_err;
  logic [1:0]       eval_best_phase;

  always_comb begin
    sym_inc  = sym_cnt_q + CntW'(1);
    // Saturating error increment
    err_next = err_cnt_q;
    if (i_error && (err_cnt_q != '1)) begin
      err_next = err_cnt_q + ERR_W'(1);
    end

    // Strict compare so ties keep the earlier (lower) phase
    eval_best_err   = best_err_q;
    eval_best_phase = best_phase_q;
    if (err_cnt_q < best_err_q) begin
      eval_best_err   = err_cnt_q;
      eval_best_phase = cur_phase_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    sym_cnt_d      = sym_cnt_q;
    err_cnt_d      = err_cnt_q;
    cur_phase_d    = cur_phase_q;
    best_phase_d   = best_phase_q;
    best_err_d     = best_err_q;
    phase_d        = phase_q;
    best_err_out_d = best_err_out_q;
    relock_d       = 1'b0;

    if (!i_enable) begin
      state_d   = StIdle;
      sym_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d      = StSettle;
            phase_d      = 2'd0;
            cur_phase_d  = 2'd0;
            best_err_d   = '1;
            best_phase_d = 2'd0;
            sym_cnt_d    = '0;
            err_cnt_d    = '0;
          end
        end
        StSettle: begin
          if (i_valid) begin
            if (sym_inc == SettleEnd) begin
              state_d   = StMeasure;
              sym_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              sym_cnt_d = sym_inc;
            end
          end
        end
        StMeasure: begin
          if (i_valid) begin
            sym_cnt_d = sym_inc;
            err_cnt_d = err_next;
            if (sym_inc == WindowEnd) begin
              state_d = StEval;
            end
          end
        end
        StEval: begin
          best_err_d   = eval_best_err;
          best_phase_d = eval_best_phase;
          sym_cnt_d    = '0;
          err_cnt_d    = '0;
          if (cur_phase_q != 2'd3) begin
            cur_phase_d = cur_phase_q + 2'd1;
            phase_d     = cur_phase_q + 2'd1;
            state_d     = StSettle;
          end else begin
            phase_d        = eval_best_phase;
            best_err_out_d = eval_best_err;
            state_d        = StLock;
          end
        end
        StLock: begin
          if (i_valid) begin
            if (sym_inc == WindowEnd) begin
              sym_cnt_d = '0;
              err_cnt_d = '0;
              if (err_next > RelockThr) begin
                relock_d     = 1'b1;
                state_d      = StSettle;
                phase_d      = 2'd0;
                cur_phase_d  = 2'd0;
                best_err_d   = '1;
                best_phase_d = 2'd0;
              end
            end else begin
              sym_cnt_d = sym_inc;
              err_cnt_d = err_next;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      sym_cnt_q      <= '0;
      err_cnt_q      <= '0;
      cur_phase_q    <= 2'd0;
      best_phase_q   <= 2'd0;
      best_err_q     <= '0;
      phase_q        <= 2'd0;
      best_err_out_q <= '0;
      relock_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sym_cnt_q      <= sym_cnt_d;
      err_cnt_q      <= err_cnt_d;
      cur_phase_q    <= cur_phase_d;
      best_phase_q   <= best_phase_d;
      best_err_q     <= best_err_d;
      phase_q        <= phase_d;
      best_err_out_q <= best_err_out_d;
      relock_q       <= relock_d;
    end
  end

  assign o_phase    = phase_q;
  assign o_best_err = best_err_out_q;
  assign o_relock   = relock_q;
  assign o_locked   = (state_q == StLock);
  assign o_busy     = (state_q == StSettle) || (state_q == StMeasure) || (state_q == StEval);

endmodule

// File: tb/tb_phase_search_ctrl.sv
// Scoreboard bench for phase_search_ctrl: two instances (normal and saturating counters)
// share stimulus; lock and relock events are checked against a queue of expected results.
module tb_phase_search_ctrl;

  logic       clk = 1'b0;
  logic       rst, i_start, i_valid, i_error, en_a, en_b;
  logic [1:0] a_phase, b_phase;
  logic       a_locked, a_busy, a_relock, b_locked, b_busy, b_relock;
  logic [3:0] a_best;
  logic [2:0] b_best;

  always #5 clk = ~clk;

  phase_search_ctrl #(
    .SETTLE_SYMS(2), .WINDOW_SYMS(8), .ERR_W(4), .RELOCK_THR(2)
  ) dut_a (
    .clk(clk), .rst(rst), .i_enable(en_a), .i_start(i_start), .i_valid(i_valid),
    .i_error(i_error), .o_phase(a_phase), .o_locked(a_locked), .o_busy(a_busy),
    .o_best_err(a_best), .o_relock(a_relock)
  );

  phase_search_ctrl #(
    .SETTLE_SYMS(2), .WINDOW_SYMS(10), .ERR_W(3), .RELOCK_THR(2)
  ) dut_b (
    .clk(clk), .rst(rst), .i_enable(en_b), .i_start(i_start), .i_valid(i_valid),
    .i_error(i_error), .o_phase(b_phase), .o_locked(b_locked), .o_busy(b_busy),
    .o_best_err(b_best), .o_relock(b_relock)
  );

  typedef struct {
    bit relock;
    int phase;
    int best;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   win_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_best[2];
  int   last_phase[2];
  int   errs[4];
  int   k;
  logic a_lprev = 1'b0, a_rprev = 1'b0, b_lprev = 1'b0, b_rprev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic int phase_of(input int sel);
    return (sel != 0) ? int'(b_phase) : int'(a_phase);
  endfunction
  function automatic int busy_of(input int sel);
    return (sel != 0) ? int'(b_busy) : int'(a_busy);
  endfunction
  function automatic int locked_of(input int sel);
    return (sel != 0) ? int'(b_locked) : int'(a_locked);
  endfunction
  function automatic int best_of(input int sel);
    return (sel != 0) ? int'(b_best) : int'(a_best);
  endfunction

  task automatic push_exp(input int sel, input bit relock, input int phase, input int best);
    exp_t e;
    e.relock = relock;
    e.phase  = phase;
    e.best   = best;
    if (sel != 0) qb.push_back(e);
    else qa.push_back(e);
  endtask

  // Monitor: every lock entry and relock pulse must match the next queued expectation
  task automatic mon_evt(input int sel, input logic locked, input logic lprev,
                         input logic relock, input logic rprev, input int phase,
                         input int best);
    exp_t e;
    bit   have;
    if (locked && !lprev) begin
      have = (sel != 0) ? (qb.size() != 0) : (qa.size() != 0);
      if (!have) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_lock dut%0d: got lock, expected none", sel);
      end else begin
        e = (sel != 0) ? qb.pop_front() : qa.pop_front();
        chk("lock_kind", int'(e.relock), 0);
        chk("lock_phase", phase, e.phase);
        chk("lock_best_err", best, e.best);
      end
    end
    if (relock) begin
      have = (sel != 0) ? (qb.size() != 0) : (qa.size() != 0);
      if (!have) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_relock dut%0d: got relock, expected none", sel);
      end else begin
        e = (sel != 0) ? qb.pop_front() : qa.pop_front();
        chk("relock_kind", int'(e.relock), 1);
        chk("relock_locked", int'(locked), 0);
        chk("relock_phase", phase, e.phase);
      end
    end
    if (rprev) chk("relock_width", int'(relock), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_evt(0, a_locked, a_lprev, a_relock, a_rprev, int'(a_phase), int'(a_best));
      mon_evt(1, b_locked, b_lprev, b_relock, b_rprev, int'(b_phase), int'(b_best));
    end
    a_lprev <= a_locked;
    a_rprev <= a_relock;
    b_lprev <= b_locked;
    b_rprev <= b_relock;
  end

  // One symbol every 4th clock
  task automatic strobe(input bit e);
    @(negedge clk);
    i_valid = 1'b1;
    i_error = e;
    @(negedge clk);
    i_valid = 1'b0;
    i_error = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Window of w strobes with exactly n errors at random positions
  task automatic make_window(input int w, input int n);
    bit t;
    int j;
    win_q = {};
    for (int i = 0; i < w; i++) win_q.push_back(i < n);
    for (int i = w - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = win_q[i];
      win_q[i] = win_q[j];
      win_q[j] = t;
    end
  endtask

  task automatic run_search(input int sel, input bit do_start, input int e_in[4],
                            input int abort_phase);
    int w       = (sel != 0) ? 10 : 8;
    int sat_max = (sel != 0) ? 7 : 15;
    int bp      = 0;
    int bv      = 1 << 30;
    for (int p = 0; p < 4; p++) begin
      int c = (e_in[p] > sat_max) ? sat_max : e_in[p];
      if (c < bv) begin
        bv = c;
        bp = p;
      end
    end
    if (abort_phase < 0) push_exp(sel, 1'b0, bp, bv);
    if (do_start) begin
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      chk("search_phase", phase_of(sel), p);
      chk("search_busy", busy_of(sel), 1);
      repeat (2) strobe(1'($urandom_range(0, 1)));
      make_window(w, e_in[p]);
      for (int i = 0; i < w; i++) begin
        if (p == abort_phase && i == w / 2) begin
          en_a = 1'b0;
          @(negedge clk);
          chk("disable_busy", int'(a_busy), 0);
          chk("disable_locked", int'(a_locked), 0);
          chk("disable_phase_hold", int'(a_phase), p);
          i_start = 1'b1;
          @(negedge clk);
          i_start = 1'b0;
          @(negedge clk);
          chk("disabled_start_ignored", int'(a_busy), 0);
          chk("disable_best_kept", int'(a_best), last_best[0]);
          en_a = 1'b1;
          @(negedge clk);
          chk("reenable_idle", int'(a_busy), 0);
          return;
        end
        if (p == 3 && i == w - 1) begin
          @(negedge clk);
          i_valid = 1'b1;
          i_error = win_q[i];
          @(negedge clk);
          i_valid = 1'b0;
          i_error = 1'b0;
          chk("eval_busy", busy_of(sel), 1);
          chk("eval_not_locked", locked_of(sel), 0);
          @(negedge clk);
          chk("lock_timing", locked_of(sel), 1);
          chk("lock_not_busy", busy_of(sel), 0);
        end else begin
          strobe(win_q[i]);
        end
      end
    end
    last_best[sel]  = bv;
    last_phase[sel] = bp;
  endtask

  task automatic lock_window(input int n);
    if (n > 2) push_exp(0, 1'b1, 0, 0);
    make_window(8, n);
    for (int i = 0; i < 8; i++) strobe(win_q[i]);
    if (n > 2) begin
      chk("after_relock_locked", int'(a_locked), 0);
      chk("after_relock_phase", int'(a_phase), 0);
      chk("after_relock_busy", int'(a_busy), 1);
    end else begin
      chk("stay_locked", int'(a_locked), 1);
      chk("stay_phase", int'(a_phase), last_phase[0]);
    end
  endtask

  initial begin
    rst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_error = 1'b0; en_a = 1'b1; en_b = 1'b1;
    last_best = '{0, 0};
    last_phase = '{0, 0};
    repeat (3) begin
      @(negedge clk);
      chk("rst_phase_a", int'(a_phase), 0);
      chk("rst_locked_a", int'(a_locked), 0);
      chk("rst_busy_a", int'(a_busy), 0);
      chk("rst_best_a", int'(a_best), 0);
      chk("rst_relock_a", int'(a_relock), 0);
      chk("rst_busy_b", int'(b_busy), 0);
      chk("rst_best_b", int'(b_best), 0);
      i_start = ~i_start;
      i_valid = ~i_valid;
    end
    @(negedge clk);
    rst = 1'b1; en_b = 1'b0; i_start = 1'b0; i_valid = 1'b0;
    @(negedge clk);

    errs = '{8, 8, 0, 8};
    run_search(0, 1'b1, errs, -1);
    lock_window(2);
    lock_window(3);
    errs = '{3, 1, 1, 5};
    run_search(0, 1'b0, errs, -1);

    repeat (6) begin
      k = $urandom_range(0, 5);
      lock_window(k);
      if (k > 2) begin
        for (int p = 0; p < 4; p++) errs[p] = $urandom_range(0, 8);
        run_search(0, 1'b0, errs, -1);
      end
    end

    en_a = 1'b0;
    @(negedge clk);
    chk("lock_disable_locked", int'(a_locked), 0);
    chk("lock_disable_phase", int'(a_phase), last_phase[0]);
    chk("lock_disable_best", int'(a_best), last_best[0]);
    en_a = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 4; p++) errs[p] = $urandom_range(0, 8);
    run_search(0, 1'b1, errs, 1);

    en_a = 1'b0;
    en_b = 1'b1;
    @(negedge clk);
    errs = '{10, 10, 10, 10};
    run_search(1, 1'b1, errs, -1);
    en_b = 1'b0;
    @(negedge clk);

    en_a = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) strobe(1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_phase", int'(a_phase), 0);
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_best_a", int'(a_best), 0);
    chk("midrst_best_b", int'(b_best), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle", int'(a_busy), 0);

    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_search_ctrl.md
Name: phase_search_ctrl

Overview:
Controller that sequences the receiver's sampling-phase selection automatically. It sweeps all four oversampling phases, measures symbol errors over a fixed window at each phase, and selects and holds the phase with the fewest errors. In the locked state it keeps monitoring the error rate and restarts the search when errors exceed a threshold. It sits between the valid-strobe FSM, the BER comparator error flag, and the rx phase input, replacing manual switch selection of the phase.

Parameters:
SETTLE_SYMS, 16, valid strobes ignored after every phase change before counting starts.
WINDOW_SYMS, 511, valid strobes per measurement window (one PRBS9 period).
ERR_W, 10, width of error counters; counters saturate at 2^ERR_W-1.
RELOCK_THR, 8, errors per window in LOCK that trigger a new search when exceeded.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low.
i_enable  in  1  controller enable; low forces IDLE.
i_start  in  1  single-cycle request to begin a search; sampled in IDLE only.
i_valid  in  1  symbol strobe from the valid FSM (one cycle per symbol).
i_error  in  1  BER comparator mismatch flag; meaningful only when i_valid=1.
o_phase  out  2  phase select driven to rx i_phase.
o_locked  out  1  high while in LOCK.
o_busy  out  1  high in SETTLE, MEASURE or EVAL.
o_best_err  out  ERR_W  error count of the chosen phase from the last completed search.
o_relock  out  1  one-cycle pulse when LOCK exits because errors exceeded RELOCK_THR.

Behaviour:
- All state is registered on clk rising edge. When rst=0 at an edge: state=IDLE, o_phase=0, o_locked=0, o_busy=0, o_best_err=0, o_relock=0, and all counters=0.
- States: IDLE, SETTLE, MEASURE, EVAL, LOCK.
- IDLE:
  - On i_enable=1 and i_start=1, go to SETTLE on the next cycle. Set o_phase=0, cur_phase=0, best_err=all ones, best_phase=0.
  - Otherwise stay in IDLE. o_phase holds its value.
- SETTLE:
  - Count i_valid strobes.
  - After SETTLE_SYMS strobes, go to MEASURE and clear err_cnt and sym_cnt.
  - i_error is ignored in this state.
- MEASURE:
  - Each i_valid increments sym_cnt. If i_error=1, err_cnt also increments, saturating.
  - The strobe that brings sym_cnt to WINDOW_SYMS is counted, then the state moves to EVAL.
- EVAL (exactly one cycle):
  - If err_cnt < best_err (strict), then best_err=err_cnt and best_phase=cur_phase. Ties keep the lower phase.
  - If cur_phase<3: cur_phase+1, o_phase=cur_phase+1, go to SETTLE.
  - If cur_phase=3: o_phase=best_phase, o_best_err=best_err, go to LOCK.
- LOCK:
  - o_locked=1 and o_phase is held.
  - Run continuous back-to-back WINDOW_SYMS windows with no settle period, counting errors.
  - At each window end, if err_cnt > RELOCK_THR: pulse o_relock for 1 cycle, drop o_locked, and restart the search as if i_start were asserted (phase 0, SETTLE).
  - Otherwise clear the counters and continue.
  - i_start is ignored in LOCK.
- i_enable=0 in any state: next state is IDLE. o_locked, o_busy and o_relock go to 0, counters clear, o_phase holds. This is not a reset: o_best_err is retained.
- Output timing: o_busy and o_locked are decoded from registered state, so they change in the cycle after the transition condition. o_phase changes in the same cycle the state enters SETTLE or LOCK.
- i_valid and i_error arriving in the same cycle as a state transition belong to the old state's count. They are never lost and never double-counted.
- Full-search duration: 4*(SETTLE_SYMS+WINDOW_SYMS) strobes plus 5 clk cycles after i_start.
- Reset mid-search: return to reset values immediately. No partial result is published.

Test Plan:
All scenarios use SETTLE_SYMS=2, WINDOW_SYMS=8, RELOCK_THR=2, ERR_W=4, and i_valid every 4th clk.
1. Reset: hold rst=0 for 3 cycles while i_start and i_valid toggle -> o_phase=0, o_locked=0, o_busy=0, o_best_err=0 throughout.
2. Clean sweep: i_error=1 on every strobe except when o_phase=2 -> phases step 0,1,2,3 with o_busy=1; LOCK with o_phase=2, o_best_err=0, o_locked=1 after 40 strobes + 5 cycles.
3. Tie: error counts 3,1,1,5 per phase -> o_phase=1, o_best_err=1.
4. Saturation: i_error=1 on all strobes, ERR_W=3, WINDOW_SYMS=10 -> counts saturate at 7; o_best_err=7, o_phase=0.
5. Relock: after lock, inject 3 errors in one window -> o_relock pulses for 1 cycle, o_locked=0, o_phase=0, state SETTLE; 2 errors in a window -> stays locked.
6. Disable mid-MEASURE at phase 1 -> IDLE next cycle, o_busy=0, o_phase stays 1; i_start is ignored while i_enable=0.
